// File: rtl/code_lock_pkg.sv
// -----------------------------------------------------------------------------
// code_lock_pkg
// Shared types and constants for the code-entry path of the security system:
// the controller state encoding, the failed-attempt counter width, the default
// interval lengths (in system clock cycles) and a saturating counter helper.
// -----------------------------------------------------------------------------
package code_lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    WAIT    = 3'd2,
    UNLOCK  = 3'd3,
    FAIL    = 3'd4,
    LOCKOUT = 3'd5
  } lock_state_e;

  localparam int FAIL_W = 3;

  localparam int DEF_CODE_W         = 3;
  localparam int DEF_TIMER_W        = 24;
  localparam int DEF_CLEAR_CYCLES   = 4000000;
  localparam int DEF_RESP_TIMEOUT   = 8000000;
  localparam int DEF_UNLOCK_CYCLES  = 10000000;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 16000000;

  // Increment the failed-attempt count, holding at all-ones instead of wrapping.
  function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] cnt);
    if (cnt == {FAIL_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + FAIL_W'(1);
    end
  endfunction

endpackage

// File: rtl/lock_interval_timer.sv
// -----------------------------------------------------------------------------
// lock_interval_timer
// Loadable down-counter shared by all timed controller states. A load takes
// priority; otherwise the count decrements and rests at zero.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (count -> 0)
//   load       load load_value on this edge
//   load_value value to load (interval length minus one)
//   zero       high while the count reads zero
// -----------------------------------------------------------------------------
module lock_interval_timer #(
  parameter int TIMER_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] count_r;

  // Interval counter: load on state entry, else count down to zero and hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {TIMER_W{1'b0}}) begin
      count_r <= count_r - TIMER_W'(1);
    end
  end

  assign zero = (count_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/code_entry_controller.sv
// -----------------------------------------------------------------------------
// code_entry_controller
// User-side controller for the code lock. Latches the entered code, clears the
// comparator's sticky flags, requests a check, then unlocks on a match or
// counts a failure (mismatch, fault or timeout). Enough consecutive failures
// raise a timed lockout alarm.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   sw         code switches, sampled on an accepted enter
//   enter      single-cycle request pulse (honoured only in IDLE)
//   match      comparator: code equal (sticky)
//   not_match  comparator: code differs (sticky)
//   code_out   latched code to the comparator
//   check      comparison request
//   cmp_clear  comparator result clear
//   unlocked   lock release
//   alarm      lockout alarm
//   fail_count consecutive failed attempts
//   busy       high whenever not IDLE
// All outputs are registered and derived from the next state, so they change
// on the same edge as the state they belong to.
// -----------------------------------------------------------------------------
module code_entry_controller
  import code_lock_pkg::*;
#(
  parameter int CODE_W         = DEF_CODE_W,
  parameter int TIMER_W        = DEF_TIMER_W,
  parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
  parameter int RESP_TIMEOUT   = DEF_RESP_TIMEOUT,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] sw,
  input  logic              enter,
  input  logic              match,
  input  logic              not_match,
  output logic [CODE_W-1:0] code_out,
  output logic              check,
  output logic              cmp_clear,
  output logic              unlocked,
  output logic              alarm,
  output logic [2:0]        fail_count,
  output logic              busy
);

  // Timer load values: a state lasting N cycles is loaded with N-1.
  localparam logic [TIMER_W-1:0] CLEAR_LOAD   = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RESP_LOAD    = TIMER_W'(RESP_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  MAX_FAILS_V  = FAIL_W'(MAX_FAILS);

  lock_state_e        state_r;
  lock_state_e        state_nxt_s;
  logic [FAIL_W-1:0]  fail_r;
  logic [FAIL_W-1:0]  fail_nxt_s;
  logic [FAIL_W-1:0]  fail_inc_s;
  logic [CODE_W-1:0]  code_r;
  logic               check_r;
  logic               cmp_clear_r;
  logic               unlocked_r;
  logic               alarm_r;
  logic               busy_r;
  logic               timer_load_s;
  logic [TIMER_W-1:0] timer_value_s;
  logic               timer_zero_s;

  lock_interval_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load_s),
    .load_value(timer_value_s),
    .zero      (timer_zero_s)
  );

  // Next-state and failed-attempt counter decisions.
  always_comb begin
    state_nxt_s = state_r;
    fail_nxt_s  = fail_r;
    fail_inc_s  = fail_inc(fail_r);
    case (state_r)
      IDLE: begin
        if (enter) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        if (timer_zero_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      WAIT: begin
        // A clean match wins; not_match or both-high (fault) counts as a failure.
        if (match && !not_match) begin
          state_nxt_s = UNLOCK;
          fail_nxt_s  = {FAIL_W{1'b0}};
        end else if (not_match) begin
          state_nxt_s = FAIL;
        end else if (timer_zero_s) begin
          state_nxt_s = FAIL;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      UNLOCK: begin
        if (timer_zero_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = UNLOCK;
        end
      end
      FAIL: begin
        fail_nxt_s = fail_inc_s;
        if (fail_inc_s >= MAX_FAILS_V) begin
          state_nxt_s = LOCKOUT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKOUT: begin
        if (timer_zero_s) begin
          state_nxt_s = IDLE;
          fail_nxt_s  = {FAIL_W{1'b0}};
        end else begin
          state_nxt_s = LOCKOUT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        fail_nxt_s  = {FAIL_W{1'b0}};
      end
    endcase
  end

  // Timer is reloaded on every state change with the new state's interval.
  always_comb begin
    timer_load_s  = (state_nxt_s != state_r);
    timer_value_s = {TIMER_W{1'b0}};
    case (state_nxt_s)
      CLEAR:   timer_value_s = CLEAR_LOAD;
      WAIT:    timer_value_s = RESP_LOAD;
      UNLOCK:  timer_value_s = UNLOCK_LOAD;
      LOCKOUT: timer_value_s = LOCKOUT_LOAD;
      default: timer_value_s = {TIMER_W{1'b0}};
    endcase
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      fail_r      <= {FAIL_W{1'b0}};
      code_r      <= {CODE_W{1'b0}};
      check_r     <= 1'b0;
      cmp_clear_r <= 1'b0;
      unlocked_r  <= 1'b0;
      alarm_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fail_r      <= fail_nxt_s;
      if (state_r == IDLE && enter) begin
        code_r <= sw;
      end
      cmp_clear_r <= (state_nxt_s == CLEAR);
      check_r     <= (state_nxt_s == WAIT);
      unlocked_r  <= (state_nxt_s == UNLOCK);
      alarm_r     <= (state_nxt_s == LOCKOUT);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign code_out   = code_r;
  assign check      = check_r;
  assign cmp_clear  = cmp_clear_r;
  assign unlocked   = unlocked_r;
  assign alarm      = alarm_r;
  assign fail_count = fail_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_code_entry_controller.sv
// -----------------------------------------------------------------------------
// tb_code_entry_controller
// Directed and randomized attempts on the code-entry controller. Each attempt
// is described by its outcome (match / mismatch / fault / no response) and the
// expected output timeline is derived from the interval lengths and the
// failure-count rules, then compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_code_entry_controller;

  localparam int CLR  = 4;
  localparam int RESP = 10;
  localparam int UNL  = 6;
  localparam int LCK  = 8;
  localparam int MAXF = 3;

  localparam int K_MATCH = 0;
  localparam int K_NOTM  = 1;
  localparam int K_BOTH  = 2;
  localparam int K_NONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sw;
  logic       enter;
  logic       match;
  logic       not_match;
  logic [2:0] code_out;
  logic       check;
  logic       cmp_clear;
  logic       unlocked;
  logic       alarm;
  logic [2:0] fail_count;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         exp_fail = 0;
  logic [2:0] exp_code = 3'd0;

  always #5 clk = ~clk;

  code_entry_controller #(
    .CODE_W(3), .TIMER_W(24), .CLEAR_CYCLES(CLR), .RESP_TIMEOUT(RESP),
    .UNLOCK_CYCLES(UNL), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .enter(enter), .match(match),
    .not_match(not_match), .code_out(code_out), .check(check),
    .cmp_clear(cmp_clear), .unlocked(unlocked), .alarm(alarm),
    .fail_count(fail_count), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph, input logic e_cc, input logic e_ck,
                         input logic e_un, input logic e_al, input logic e_busy);
    chk({ph, ".cmp_clear"},  {7'd0, cmp_clear}, {7'd0, e_cc});
    chk({ph, ".check"},      {7'd0, check},     {7'd0, e_ck});
    chk({ph, ".unlocked"},   {7'd0, unlocked},  {7'd0, e_un});
    chk({ph, ".alarm"},      {7'd0, alarm},     {7'd0, e_al});
    chk({ph, ".busy"},       {7'd0, busy},      {7'd0, e_busy});
    chk({ph, ".fail_count"}, {5'd0, fail_count}, 8'(exp_fail));
    chk({ph, ".code_out"},   {5'd0, code_out},  {5'd0, exp_code});
  endtask

  // Random enter pulses with random switch values while the block is busy.
  task automatic spam(input bit en);
    enter = en && ($urandom_range(0, 2) == 0);
    sw    = 3'($urandom_range(0, 7));
  endtask

  task automatic attempt(input logic [2:0] code, input int kind, input int delay,
                         input bit do_spam, input bit clr_match, input bit abort);
    bit responded;
    int j;
    sw       = code;
    enter    = 1'b1;
    exp_code = code;
    // Comparator clear phase; a held match here must be ignored.
    for (int k = 0; k < CLR; k++) begin
      tick();
      chk_all("clear", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      match = clr_match && (k < CLR - 1);
      spam(do_spam);
    end
    // Check phase: respond after 'delay' WAIT cycles or never.
    responded = 1'b0;
    j = 0;
    while (!responded) begin
      tick();
      chk_all("wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (kind != K_NONE && j == delay) begin
        match     = (kind == K_MATCH) || (kind == K_BOTH);
        not_match = (kind == K_NOTM) || (kind == K_BOTH);
        responded = 1'b1;
      end else if (j == RESP - 1) begin
        responded = 1'b1;
      end
      spam(do_spam);
      j++;
    end
    if (kind == K_MATCH) begin
      exp_fail = 0;
      for (int u = 0; u < UNL; u++) begin
        tick();
        match     = 1'b0;
        not_match = 1'b0;
        chk_all("unlock", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        if (abort && u == 2) begin
          reset = 1'b0;
          #1;
          exp_code = 3'd0;
          exp_fail = 0;
          chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          enter = 1'b0;
          tick();
          chk_all("held_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          reset = 1'b1;
          tick();
          chk_all("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          return;
        end
        spam(do_spam);
      end
    end else begin
      tick();
      match     = 1'b0;
      not_match = 1'b0;
      chk_all("fail", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      spam(do_spam);
      exp_fail = (exp_fail >= 7) ? 7 : exp_fail + 1;
      if (exp_fail >= MAXF) begin
        for (int l = 0; l < LCK; l++) begin
          tick();
          chk_all("lockout", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
          spam(do_spam);
        end
        exp_fail = 0;
      end
    end
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    enter = 1'b0;
    sw    = 3'($urandom_range(0, 7));
  endtask

  initial begin
    reset     = 1'b0;
    enter     = 1'b0;
    match     = 1'b0;
    not_match = 1'b0;
    sw        = 3'd0;
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Correct code answered two cycles into the check.
    attempt(3'b101, K_MATCH, 2, 1'b0, 1'b0, 1'b0);
    // Three wrong codes: fail_count 1, 2, then lockout and clear.
    attempt(3'b010, K_NOTM, 0, 1'b0, 1'b0, 1'b0);
    attempt(3'b011, K_NOTM, 4, 1'b0, 1'b0, 1'b0);
    attempt(3'b110, K_NOTM, 9, 1'b0, 1'b0, 1'b0);
    // No comparator response: full timeout.
    attempt(3'b001, K_NONE, 0, 1'b0, 1'b0, 1'b0);
    // Ignored enters in every busy state, match held during clear.
    attempt(3'b111, K_NOTM, 3, 1'b1, 1'b1, 1'b0);
    attempt(3'b100, K_NOTM, 1, 1'b1, 1'b1, 1'b0);
    attempt(3'b000, K_MATCH, 5, 1'b1, 1'b1, 1'b0);
    // Fault (both high) counts as a failure; a later match resets the count.
    attempt(3'b011, K_BOTH, 2, 1'b0, 1'b0, 1'b0);
    attempt(3'b101, K_MATCH, 0, 1'b0, 1'b0, 1'b0);
    // Asynchronous reset in the middle of the unlock window.
    attempt(3'b010, K_NOTM, 1, 1'b0, 1'b0, 1'b0);
    attempt(3'b110, K_MATCH, 1, 1'b0, 1'b0, 1'b1);
    attempt(3'b001, K_MATCH, 3, 1'b0, 1'b0, 1'b0);

    // Randomized attempts.
    for (int n = 0; n < 40; n++) begin
      attempt(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, RESP - 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_entry_controller.md
Name: code_entry_controller

Overview:
- User-side controller for the code-lock path in the security system.
- Latches a user-entered code and drives it with a check request to the 3-bit code comparator. Also clears the comparator's sticky result flags between attempts.
- Consumes match/not_match and drives the lock and alarm outputs: timed unlock, failed-attempt counting, and timed lockout with alarm.

Parameters:
- CODE_W, 3, width of entered code; matches comparator input width.
- TIMER_W, 24, width of shared interval timer.
- CLEAR_CYCLES, 4000000, cycles cmp_clear is held; must span one full comparator slow-clock period.
- RESP_TIMEOUT, 8000000, cycles to wait for match/not_match before counting the attempt as failed.
- UNLOCK_CYCLES, 10000000, cycles unlocked stays high after a match.
- MAX_FAILS, 3, consecutive failures that trigger lockout; must be 1..7.
- LOCKOUT_CYCLES, 16000000, lockout/alarm duration.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- sw  in  CODE_W  code switches; sampled only on an accepted enter
- enter  in  1  synchronous single-cycle request pulse, already debounced upstream
- match  in  1  comparator result: code equal (sticky until cleared)
- not_match  in  1  comparator result: code differs (sticky until cleared)
- code_out  out  CODE_W  latched code to comparator input
- check  out  1  comparison request to comparator
- cmp_clear  out  1  comparator result clear
- unlocked  out  1  lock release
- alarm  out  1  lockout alarm
- fail_count  out  3  consecutive failed attempts
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; code_out 0; check 0; cmp_clear 0; unlocked 0; alarm 0; fail_count 0; busy 0; timer 0.
- Reset may arrive in any state. It returns the block to IDLE immediately. A pending unlock or lockout is abandoned and unlocked/alarm drop at once.
- One shared down-counter (TIMER_W bits) is loaded on each state entry with N-1, where N is the state's interval. The state exits on the edge when the timer reads 0 and the exit condition holds, so each timed state lasts exactly N cycles.
- IDLE:
  - enter=1 → latch sw into code_out at the same edge, go to CLEAR.
  - enter is ignored in every other state; no queueing.
- CLEAR:
  - cmp_clear=1 and check=0 for exactly CLEAR_CYCLES cycles, then go to WAIT.
  - match/not_match are ignored in this state.
- WAIT:
  - check=1 and cmp_clear=0; the timer is loaded with RESP_TIMEOUT-1.
  - match=1 and not_match=0 → go to UNLOCK; fail_count clears to 0 at the same edge.
  - not_match=1, or both inputs high (fault) → go to FAIL.
  - Timer reaches 0 with neither input high → go to FAIL.
  - The result is sampled every cycle. The first cycle in which it is valid wins.
- UNLOCK:
  - unlocked=1 and check=0 for UNLOCK_CYCLES cycles, then go to IDLE.
  - On leaving UNLOCK, unlocked=0 and cmp_clear is not pulsed; the next attempt clears the comparator itself.
- FAIL (one cycle):
  - check=0; fail_count increments, saturating at 7.
  - If the incremented value ≥ MAX_FAILS → go to LOCKOUT, else go to IDLE.
- LOCKOUT:
  - alarm=1 for LOCKOUT_CYCLES cycles.
  - On exit, fail_count clears to 0, alarm drops to 0, and the state returns to IDLE.
- code_out holds its value until the next accepted enter.
- Exactly one of cmp_clear, check, unlocked and alarm is high at any time, or none of them.

Decomposition:
- Package code_lock_pkg holds:
  - state enum: IDLE, CLEAR, WAIT, UNLOCK, FAIL, LOCKOUT;
  - FAIL_W=3;
  - default interval constants.
- One sub-module, lock_interval_timer: loadable TIMER_W down-counter with load, load_value and zero outputs. The FSM in code_entry_controller drives it.

Test Plan (overrides CLEAR_CYCLES=4, RESP_TIMEOUT=10, UNLOCK_CYCLES=6, LOCKOUT_CYCLES=8, MAX_FAILS=3):
- Correct code: sw=3'b101, enter pulse; match rises 2 cycles into WAIT → code_out=101, cmp_clear high 4 cycles, check high until match, unlocked high exactly 6 cycles, fail_count=0.
- Wrong code ×3: three attempts each answered with not_match → fail_count goes 1, 2, then LOCKOUT; alarm high exactly 8 cycles, then fail_count=0 and busy=0.
- Timeout: enter with no comparator response → check high exactly 10 cycles, then FAIL; fail_count=1 and state returns to IDLE.
- Ignored enter: enter pulses during CLEAR, WAIT, UNLOCK and LOCKOUT → no state change, code_out unchanged; match held during CLEAR is ignored.
- Fault and success reset: match and not_match both high in WAIT → counted as a failure. A following correct attempt with match → fail_count returns to 0.
- Async reset mid-UNLOCK: reset=0 at cycle 3 of 6 → unlocked=0 immediately, all outputs at reset values. After reset=1, a new enter is accepted.
